// File: rtl/lsu_mem_if_pkg.sv
// rtl/lsu_mem_if_pkg.sv - shared encodings for the load/store memory interface
package lsu_mem_if_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    // Reserved size or an access that straddles its natural alignment.
    function automatic logic req_is_err(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return (off != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// rtl/lsu_lane_extract.sv - selects the addressed lane(s) of a word and extends them
import lsu_mem_if_pkg::*;

module lsu_lane_extract (
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = word[7:0];
        case (offset)
            2'd0: lane_b = word[7:0];
            2'd1: lane_b = word[15:8];
            2'd2: lane_b = word[23:16];
            2'd3: lane_b = word[31:24];
            default: lane_b = word[7:0];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        result = word;
        case (size)
            SZ_BYTE: result = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
            SZ_HALF: result = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_if.sv
// rtl/lsu_mem_if.sv - byte-addressed load/store requests to word-wide Memory ports
import lsu_mem_if_pkg::*;

module lsu_mem_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [ADDR_W+1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                mem_str,
    output logic                mem_ld,
    output logic [3:0]          mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    state_t              state, next_state;
    logic                r_we;
    logic [1:0]          r_size;
    logic                r_uns;
    logic [ADDR_W+1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [31:0]         ext_data;

    lsu_lane_extract u_extract (
        .word        (mem_dout),
        .offset      (r_addr[1:0]),
        .size        (r_size),
        .is_unsigned (r_uns),
        .result      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_we    <= 1'b0;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_size  <= req_size;
                        r_uns   <= req_unsigned;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_rdata <= '0;
                        r_err   <= req_is_err(req_size, req_addr[1:0]);
                    end
                end
                S_ACCESS: begin
                    if (!r_we) r_rdata <= ext_data;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_str    = 1'b0;
        mem_ld     = 1'b0;
        mem_sel    = 4'b0000;
        mem_addr   = '0;
        mem_din    = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    next_state = req_is_err(req_size, req_addr[1:0]) ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                mem_addr = r_addr[ADDR_W+1:2];
                // Enables are gated so a reset cycle can never commit a store.
                mem_str  = r_we & ~clr;
                mem_ld   = ~r_we & ~clr;
                case (r_size)
                    SZ_BYTE: begin
                        mem_sel = 4'b0001 << r_addr[1:0];
                        mem_din = {4{r_wdata[7:0]}};
                    end
                    SZ_HALF: begin
                        mem_sel = r_addr[1] ? 4'b1100 : 4'b0011;
                        mem_din = {2{r_wdata[15:0]}};
                    end
                    default: begin
                        mem_sel = 4'b1111;
                        mem_din = r_wdata;
                    end
                endcase
                next_state = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                resp_err   = r_err;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_if.sv
// tb/tb_lsu_mem_if.sv - directed self-checking bench for lsu_mem_if
module tb_lsu_mem_if;

    localparam int ADDR_W = 20;

    logic              clk = 1'b0;
    logic              clr;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W+1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              mem_str;
    logic              mem_ld;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    logic [31:0] mem [16];

    int n_checks = 0;
    int n_fail   = 0;
    longint t_hs1, t_hs2;

    always #5 clk = ~clk;

    lsu_mem_if #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .clr          (clr),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_str      (mem_str),
        .mem_ld       (mem_ld),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    assign mem_dout = mem_ld ? mem[mem_addr[3:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_str) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request, wait (bounded) for req_ready, and return #1 after the handshake edge.
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [ADDR_W+1:0] addr, input logic [31:0] wdata);
        int k;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        k = 0;
        while (!req_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("handshake_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [ADDR_W+1:0] addr, input logic [31:0] exp);
        send(1'b0, size, uns, addr, 32'd0);
        @(negedge clk);
        check({tag, "_ld"}, {31'd0, mem_ld}, 32'd1);
        @(negedge clk);
        check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
        check({tag, "_rdata"}, resp_rdata, exp);
        check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[3] = 32'h80FF7F01;
        clr = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        repeat (2) @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_mem_ctl", {28'd0, mem_str, mem_ld, resp_err, 1'b0}, 32'd0);
        check("rst_mem_sel", {28'd0, mem_sel}, 32'd0);
        check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);

        // store word 0x11111111 to 0x4
        send(1'b1, 2'b10, 1'b0, 22'h4, 32'h11111111);
        @(negedge clk);
        check("sw_addr", {12'd0, mem_addr}, 32'd1);
        check("sw_sel", {28'd0, mem_sel}, 32'hF);
        check("sw_str", {31'd0, mem_str}, 32'd1);
        check("sw_ld", {31'd0, mem_ld}, 32'd0);
        check("sw_din", mem_din, 32'h11111111);
        check("sw_no_early_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check("sw_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("sw_resp_err", {31'd0, resp_err}, 32'd0);
        check("sw_resp_rdata", resp_rdata, 32'd0);
        check("sw_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("sw_resp_done", {31'd0, resp_valid}, 32'd0);
        check("sw_mem1", mem[1], 32'h11111111);

        // store byte 0xAB to 0x9
        send(1'b1, 2'b00, 1'b0, 22'h9, 32'h000000AB);
        @(negedge clk);
        check("sb_addr", {12'd0, mem_addr}, 32'd2);
        check("sb_sel", {28'd0, mem_sel}, 32'h2);
        check("sb_din", mem_din, 32'hABABABAB);
        check("sb_str", {31'd0, mem_str}, 32'd1);
        @(negedge clk);
        check("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
        check("sb_mem2", mem[2], 32'h0000AB00);

        // loads from word 3 = 0x80FF7F01
        do_load("lb_c", 2'b00, 1'b0, 22'hC, 32'h00000001);
        do_load("lb_e", 2'b00, 1'b0, 22'hE, 32'hFFFFFFFF);
        do_load("lbu_e", 2'b00, 1'b1, 22'hE, 32'h000000FF);
        do_load("lh_e", 2'b01, 1'b0, 22'hE, 32'hFFFF80FF);
        do_load("lhu_c", 2'b01, 1'b1, 22'hC, 32'h00007F01);
        do_load("lw_c", 2'b10, 1'b1, 22'hC, 32'h80FF7F01);

        // misaligned halfword, reserved size, misaligned word
        send(1'b0, 2'b01, 1'b0, 22'h5, 32'd0);
        @(negedge clk);
        check("lh5_valid", {31'd0, resp_valid}, 32'd1);
        check("lh5_err", {31'd0, resp_err}, 32'd1);
        check("lh5_rdata", resp_rdata, 32'd0);
        check("lh5_no_mem", {30'd0, mem_str, mem_ld}, 32'd0);
        send(1'b1, 2'b11, 1'b0, 22'h0, 32'h55555555);
        @(negedge clk);
        check("rsvd_valid", {31'd0, resp_valid}, 32'd1);
        check("rsvd_err", {31'd0, resp_err}, 32'd1);
        check("rsvd_no_mem", {30'd0, mem_str, mem_ld}, 32'd0);
        send(1'b0, 2'b10, 1'b0, 22'h6, 32'd0);
        @(negedge clk);
        check("lw6_err", {30'd0, resp_valid, resp_err}, 32'd3);
        @(negedge clk);
        check("err_resp_done", {31'd0, resp_valid}, 32'd0);
        check("rsvd_mem0", mem[0], 32'd0);

        // reset during the ACCESS cycle of a store word to 0x8
        send(1'b1, 2'b10, 1'b0, 22'h8, 32'hDEADBEEF);
        clr = 1'b1;
        @(negedge clk);
        check("clr_str_gated", {31'd0, mem_str}, 32'd0);
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        check("clr_no_resp", {31'd0, resp_valid}, 32'd0);
        check("clr_ready", {31'd0, req_ready}, 32'd1);
        check("clr_mem2", mem[2], 32'h0000AB00);

        // back-to-back loads with req_valid held high
        req_we = 1'b0;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 22'h4;
        req_wdata = 32'd0;
        req_valid = 1'b1;
        check("b2b_ready1", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        t_hs1 = $time;
        #1 req_addr = 22'h8;
        @(negedge clk);
        check("b2b_addr1", {12'd0, mem_addr}, 32'd1);
        check("b2b_ready_access", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("b2b_valid1", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata1", resp_rdata, 32'h11111111);
        @(negedge clk);
        check("b2b_ready2", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        t_hs2 = $time;
        #1 req_valid = 1'b0;
        check("b2b_spacing", 32'(t_hs2 - t_hs1), 32'd30);
        @(negedge clk);
        check("b2b_addr2", {12'd0, mem_addr}, 32'd2);
        @(negedge clk);
        check("b2b_valid2", {31'd0, resp_valid}, 32'd1);
        check("b2b_rdata2", resp_rdata, 32'h0000AB00);
        @(negedge clk);
        check("b2b_idle", {31'd0, resp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store interface stage that sits directly upstream of the data Memory block and drives its str/ld/sel/addr/data_in ports.
- Accepts one byte-addressed CPU load/store request per transaction over a valid/ready handshake.
- Converts each request into a word address, a byte-lane select and replicated store data.
- Returns the lane-extracted, sign- or zero-extended load data, or an error response, on a one-cycle response strobe.

Parameters:
- ADDR_W, 20, word-address width presented to Memory; byte address width is ADDR_W+2.
- DATA_W, 32, data width; fixed at 32, 4 byte lanes.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid & req_ready at a clk edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- req_unsigned  in  1  load zero-extend (1) or sign-extend (0); ignored for stores and word loads.
- req_addr  in  ADDR_W+2  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid; misaligned access or reserved size.
- mem_str  out  1  Memory store enable.
- mem_ld  out  1  Memory load enable.
- mem_sel  out  4  Memory byte-lane select; bit i = bits [8i+7:8i].
- mem_addr  out  ADDR_W  Memory word address.
- mem_din  out  32  Memory write data.
- mem_dout  in  32  Memory read data; combinational while mem_ld = 1.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset: state = IDLE. All outputs are 0 except req_ready = 1. Request registers are cleared.
- IDLE:
  - req_ready = 1. All mem_* outputs are 0.
  - On handshake: latch we, size, unsigned, addr and wdata.
  - Legal request: go to ACCESS.
  - Error request: go to RESP with err = 1 and no Memory access.
- Error conditions:
  - size = 11.
  - halfword with addr[0] = 1.
  - word with addr[1:0] != 00.
- ACCESS (exactly one cycle):
  - mem_addr = addr[ADDR_W+1:2].
  - mem_str = we. mem_ld = ~we.
  - mem_sel:
    - byte: one-hot at addr[1:0].
    - halfword: offset 0 gives 0011; offset 2 gives 1100.
    - word: 1111.
  - mem_din: byte = {4{wdata[7:0]}}; halfword = {2{wdata[15:0]}}; word = wdata.
  - For loads, at the closing edge capture mem_dout >> (8*addr[1:0]), masked to the access size, then sign- or zero-extended into the rdata register. Word loads are captured unmodified.
  - Next state: RESP.
- RESP (exactly one cycle):
  - resp_valid = 1; resp_rdata and resp_err come from registers.
  - req_ready = 0.
  - Next state: IDLE.
- Latency: handshake at edge N, Memory access in cycle N+1, resp_valid high in cycle N+2. Throughput is one request per 3 cycles.
- Error latency: handshake at edge N, resp_valid high in cycle N+1.
- All mem_* outputs are registered-state decodes. mem_str and mem_ld are additionally gated by ~clr, so no store or load occurs in a cycle where clr = 1.
- Reset mid-operation: clr in ACCESS or RESP returns to IDLE at the edge. The pending response is dropped and no resp_valid is issued.
- req_valid while req_ready = 0 is ignored. The requester must hold the request until the handshake.

Decomposition:
- Shared package: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and state encodings (S_IDLE, S_ACCESS, S_RESP).
- One combinational sub-module, lsu_lane_extract: takes the 32-bit word, offset, size and unsigned flag; outputs the extended 32-bit result.
- Sel and din generation stays inline.

Test Plan:
1. Store word 0x11111111 to byte address 0x4. Expected in ACCESS: mem_addr = 1, mem_sel = 1111, mem_str = 1. Then resp_valid with err = 0 two cycles after the handshake.
2. Store byte 0xAB to address 0x9. Expected: mem_addr = 2, mem_sel = 0010, mem_din = 0xABABABAB.
3. Load bytes from word 3, with the Memory model holding 0x80FF7F01 there:
   - lb at 0xC returns 0x00000001.
   - lb at 0xE returns 0xFFFFFFFF.
   - lbu at 0xE returns 0x000000FF.
   - lh at 0xE returns 0xFFFF80FF.
4. Load halfword at address 0x5 returns resp_err = 1 one cycle after the handshake, with no mem_ld/mem_str pulse. A request with size = 11 gives the same result.
5. Assert clr during the ACCESS cycle of a store word to 0x8. Expected: mem_str = 0 in that cycle, Memory word 2 unchanged, no resp_valid, req_ready = 1 in the next cycle.
6. Hold req_valid high for back-to-back loads of word 1 then word 2. Expected: handshakes exactly 3 cycles apart and responses in order, with correct data.
